uart_tx_stream_buffer: RTL and testbench

- Buffering stage between the command parser's byte output (`out_en_o`/`out_data_o`) and the UART interface transmit port (`tx_irq_i`/`tx_data_i`/`tx_busy_o`).
- Accepts 1-clk byte strobes at any rate into a FIFO.
- Drains the FIFO one byte at a time, honouring the UART's busy handshake, so no byte is lost to `tx_busy`.
- Optionally inserts LF (0x0A) after every CR (0x0D) for terminal-friendly echo.

---
 rtl/uart_tx_stream_buffer_if.sv | 27 ++
 rtl/uart_tx_stream_buffer.sv | 136 +++++++++++++
 tb/tb_uart_tx_stream_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_stream_buffer_if.sv
// Byte-stream buffer bundle: parser-side write strobe/status plus UART transmit handshake.
// Latency: none, wires only.
// Backpressure: in_full_o on the write side, tx_busy_i on the UART side.
interface uart_tx_stream_buffer_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  in_en_i;
   logic [7:0]            in_data_i;
   logic                  in_full_o;
   logic [DEPTH_LOG2:0]   level_o;
   logic                  overflow_o;
   logic                  tx_irq_o;
   logic [7:0]            tx_data_o;
   logic                  tx_busy_i;

   // Buffer side: suffixes are named from the buffer's point of view.
   modport slave (
      input  in_en_i, in_data_i, tx_busy_i,
      output in_full_o, level_o, overflow_o, tx_irq_o, tx_data_o
   );

   // Producer / UART side.
   modport master (
      output in_en_i, in_data_i, tx_busy_i,
      input  in_full_o, level_o, overflow_o, tx_irq_o, tx_data_o
   );
endinterface

// File: rtl/uart_tx_stream_buffer.sv
// Buffers parser bytes in a FIFO and feeds them one at a time to the UART, optional LF after CR.
// Latency: write to tx_irq_o pulse is 2 clocks minimum (empty FIFO, UART idle).
// Backpressure: writes while full are dropped (sticky overflow); drain waits on tx_busy_i with ack timeout.
module uart_tx_stream_buffer #(
   parameter int DEPTH_LOG2      = 4,
   parameter bit CRLF_EXPAND     = 1'b1,
   parameter int ACK_TIMEOUT_CLK = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   uart_tx_stream_buffer_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = $clog2(ACK_TIMEOUT_CLK + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_DRAIN} state_t;

   logic [7:0]          mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic                overflow_q, overflow_d;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                lf_pend_q, lf_pend_d;
   logic                tx_irq_q, tx_irq_d;
   logic [7:0]          tx_data_q, tx_data_d;

   logic                full, empty, wr_fire, pop;
   logic [7:0]          head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign wr_fire = bus.in_en_i && !full;
   assign head    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // Storage array, written only when there is room.
   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.in_data_i;
      end
   end

   // Pointer and sticky overflow next-state; full uses this cycle's registered pointers.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (bus.in_en_i && full) begin
         overflow_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Drain FSM: pending LF beats FIFO data; ACK gives up after the timeout and counts the byte as sent.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lf_pend_d = lf_pend_q;
      tx_irq_d  = 1'b0;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lf_pend_q && !bus.tx_busy_i) begin
               tx_data_d = 8'h0A;
               tx_irq_d  = 1'b1;
               lf_pend_d = 1'b0;
               cnt_d     = '0;
               state_d   = ST_ACK;
            end else if (!empty && !bus.tx_busy_i) begin
               tx_data_d = head;
               tx_irq_d  = 1'b1;
               pop       = 1'b1;
               if (CRLF_EXPAND && (head == 8'h0D)) begin
                  lf_pend_d = 1'b1;
               end
               cnt_d     = '0;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.tx_busy_i) begin
               state_d = ST_DRAIN;
            end else if (cnt_q == CW'(ACK_TIMEOUT_CLK - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            if (!bus.tx_busy_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset discards queued bytes and any pending LF.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lf_pend_q  <= 1'b0;
         tx_irq_q   <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lf_pend_q  <= lf_pend_d;
         tx_irq_q   <= tx_irq_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.in_full_o  = full;
   assign bus.level_o    = wr_ptr_q - rd_ptr_q;
   assign bus.overflow_o = overflow_q;
   assign bus.tx_irq_o   = tx_irq_q;
   assign bus.tx_data_o  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_stream_buffer.sv
// Directed bench for uart_tx_stream_buffer: two instances, CR->LF expansion on (a) and off (b).
// Latency: checks the 2-clock write-to-pulse path and the 16-clock timeout-driven pulse spacing.
// Backpressure: a UART stub raises busy one clock after each pulse; a force flag holds busy high.
module tb_uart_tx_stream_buffer;
   localparam int DL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_stream_buffer_if #(.DEPTH_LOG2(DL)) bus_a ();
   uart_tx_stream_buffer_if #(.DEPTH_LOG2(DL)) bus_b ();

   uart_tx_stream_buffer #(.DEPTH_LOG2(DL), .CRLF_EXPAND(1'b1), .ACK_TIMEOUT_CLK(15)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );
   uart_tx_stream_buffer #(.DEPTH_LOG2(DL), .CRLF_EXPAND(1'b0), .ACK_TIMEOUT_CLK(15)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   logic       in_en      = 1'b0;
   logic [7:0] in_dat     = 8'h00;
   logic       force_busy = 1'b0;
   logic       stub_on    = 1'b1;
   int         busy_len   = 3;
   logic       stub_busy [2] = '{1'b0, 1'b0};
   int         busy_ctr  [2] = '{0, 0};
   logic       arm       [2] = '{1'b0, 1'b0};
   logic       prev_irq  [2] = '{1'b0, 1'b0};

   assign bus_a.in_en_i   = in_en;
   assign bus_a.in_data_i = in_dat;
   assign bus_a.tx_busy_i = stub_busy[0] | force_busy;
   assign bus_b.in_en_i   = in_en;
   assign bus_b.in_data_i = in_dat;
   assign bus_b.tx_busy_i = stub_busy[1] | force_busy;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] a_dat [$];
   logic [7:0] b_dat [$];
   int         a_cyc [$];
   int         viol = 0;
   int         n_chk = 0;
   int         n_bad = 0;
   int         last_w = 0;

   // Capture pulses, watch pulse rules, and model the UART busy response.
   always @(negedge clk) begin
      logic       irq_v  [2];
      logic [7:0] dat_v  [2];
      logic       busy_v [2];
      irq_v[0]  = bus_a.tx_irq_o;
      irq_v[1]  = bus_b.tx_irq_o;
      dat_v[0]  = bus_a.tx_data_o;
      dat_v[1]  = bus_b.tx_data_o;
      busy_v[0] = bus_a.tx_busy_i;
      busy_v[1] = bus_b.tx_busy_i;
      if (irq_v[0]) begin
         a_dat.push_back(dat_v[0]);
         a_cyc.push_back(cyc);
      end
      if (irq_v[1]) b_dat.push_back(dat_v[1]);
      for (int i = 0; i < 2; i++) begin
         if (irq_v[i] && prev_irq[i]) viol++;
         if (irq_v[i] && busy_v[i]) viol++;
         prev_irq[i] = irq_v[i];
         if (rst) begin
            stub_busy[i] = 1'b0;
            busy_ctr[i]  = 0;
            arm[i]       = 1'b0;
         end else begin
            if (busy_ctr[i] > 0) begin
               busy_ctr[i]--;
               if (busy_ctr[i] == 0) stub_busy[i] = 1'b0;
            end
            if (arm[i]) begin
               arm[i]       = 1'b0;
               stub_busy[i] = 1'b1;
               busy_ctr[i]  = busy_len;
            end
            if (irq_v[i] && stub_on) arm[i] = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Raise the strobe for the next clock; consecutive calls give back-to-back writes.
   task automatic wr(input logic [7:0] b);
      @(negedge clk);
      in_en  = 1'b1;
      in_dat = b;
      last_w = cyc;
   endtask

   task automatic wr_end();
      @(negedge clk);
      in_en = 1'b0;
   endtask

   task automatic clear_q();
      a_dat.delete();
      b_dat.delete();
      a_cyc.delete();
   endtask

   task automatic wait_out(input string tag, input int na, input int nb);
      int k;
      k = 0;
      while (!(a_dat.size() >= na && b_dat.size() >= nb) && k < 6000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_arrived"}, int'(a_dat.size() >= na && b_dat.size() >= nb), 1);
   endtask

   initial begin
      int w;
      // Reset state
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_level", int'(bus_a.level_o), 0);
      check("rst_full", int'(bus_a.in_full_o), 0);
      check("rst_ovf", int'(bus_a.overflow_o), 0);
      check("rst_irq", int'(bus_a.tx_irq_o), 0);
      check("rst_data", int'(bus_a.tx_data_o), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte: pulse two clocks after the write strobe
      busy_len = 100;
      clear_q();
      wr(8'h41);
      w = last_w;
      wr_end();
      check("single_level_after_write", int'(bus_a.level_o), 1);
      wait_out("single", 1, 1);
      repeat (110) @(negedge clk);
      check("single_count", a_dat.size(), 1);
      check("single_data", int'(a_dat[0]), 'h41);
      check("single_latency", a_cyc[0] - w, 2);
      check("single_level_end", int'(bus_a.level_o), 0);

      // Burst of 16 into a held-off UART, then drain in order
      busy_len = 200;
      clear_q();
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
      wr_end();
      check("burst_full", int'(bus_a.in_full_o), 1);
      check("burst_level", int'(bus_a.level_o), 16);
      check("burst_ovf", int'(bus_a.overflow_o), 0);
      force_busy = 1'b0;
      wait_out("burst", 16, 16);
      repeat (210) @(negedge clk);
      check("burst_count", a_dat.size(), 16);
      for (int i = 0; i < 16; i++) check("burst_byte", int'(a_dat[i]), 'h30 + i);

      // Overflow: 17th byte dropped, sticky flag
      busy_len = 3;
      clear_q();
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) wr(8'h70 + 8'(i));
      wr_end();
      check("ovf_flag", int'(bus_a.overflow_o), 1);
      check("ovf_level", int'(bus_a.level_o), 16);
      force_busy = 1'b0;
      wait_out("ovf", 16, 16);
      repeat (20) @(negedge clk);
      check("ovf_count", a_dat.size(), 16);
      check("ovf_first", int'(a_dat[0]), 'h70);
      check("ovf_last", int'(a_dat[15]), 'h7F);
      check("ovf_sticky", int'(bus_a.overflow_o), 1);

      // CR handling: expansion on a, pass-through on b
      clear_q();
      wr(8'h61);
      wr(8'h0D);
      wr(8'h62);
      wr_end();
      wait_out("crlf", 4, 3);
      repeat (20) @(negedge clk);
      check("crlf_a_count", a_dat.size(), 4);
      check("crlf_a0", int'(a_dat[0]), 'h61);
      check("crlf_a1", int'(a_dat[1]), 'h0D);
      check("crlf_a2", int'(a_dat[2]), 'h0A);
      check("crlf_a3", int'(a_dat[3]), 'h62);
      check("crlf_b_count", b_dat.size(), 3);
      check("crlf_b0", int'(b_dat[0]), 'h61);
      check("crlf_b1", int'(b_dat[1]), 'h0D);
      check("crlf_b2", int'(b_dat[2]), 'h62);

      // Ack timeout: busy never rises; 15 ACK clocks + 1 IDLE clock between pulses
      stub_on = 1'b0;
      clear_q();
      wr(8'h11);
      w = last_w;
      wr(8'h22);
      wr_end();
      wait_out("tmo", 2, 2);
      check("tmo_first_latency", a_cyc[0] - w, 2);
      check("tmo_d0", int'(a_dat[0]), 'h11);
      check("tmo_d1", int'(a_dat[1]), 'h22);
      check("tmo_gap", a_cyc[1] - a_cyc[0], 16);
      repeat (20) @(negedge clk);
      check("tmo_level_end", int'(bus_a.level_o), 0);
      stub_on = 1'b1;

      // Reset while draining with 5 bytes still queued
      busy_len = 100;
      clear_q();
      for (int i = 0; i < 6; i++) wr(8'h80 + 8'(i));
      wr_end();
      repeat (2) @(negedge clk);
      check("rstmid_level_before", int'(bus_a.level_o), 5);
      rst = 1'b1;
      #1;
      check("rstmid_level", int'(bus_a.level_o), 0);
      check("rstmid_irq", int'(bus_a.tx_irq_o), 0);
      check("rstmid_ovf", int'(bus_a.overflow_o), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
      repeat (50) @(negedge clk);
      check("rstmid_quiet_a", a_dat.size(), 0);
      check("rstmid_quiet_b", b_dat.size(), 0);
      wr(8'h55);
      w = last_w;
      wr_end();
      wait_out("rstmid_new", 1, 1);
      check("rstmid_new_data", int'(a_dat[0]), 'h55);
      check("rstmid_new_latency", a_cyc[0] - w, 2);

      repeat (5) @(negedge clk);
      check("pulse_rules", viol, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
